// File: rtl/cpu16_pkg.sv
// Shared CPU16 bus definitions: bus widths and the memory access FSM states.
package cpu16_pkg;

  localparam int unsigned CPU16_DATA_W = 16;
  localparam int unsigned CPU16_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/cpu_mem_ram.sv
// Word array behind cpu_wait_mem: one CPU write port, one preload write port and a
// registered read port. No reset on the array, so it maps onto block RAM.
module cpu_mem_ram #(
  parameter int unsigned DataW     = 16,
  parameter int unsigned DepthLog2 = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [DepthLog2-1:0] waddr_i,
  input  logic [DataW-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [DepthLog2-1:0] raddr_i,
  input  logic                 ld_en_i,
  input  logic [DepthLog2-1:0] ld_addr_i,
  input  logic [DataW-1:0]     ld_data_i,
  output logic [DataW-1:0]     rdata_o
);

  localparam int unsigned Words = 1 << DepthLog2;

  logic [DataW-1:0] mem_q [Words];
  logic [DataW-1:0] rdata_q;

  // Preload wins over a CPU write to the same word; read data only moves on re_i.
  always_ff @(posedge clk_i) begin
    if (we_i && !(ld_en_i && (ld_addr_i == waddr_i))) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (ld_en_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_wait_mem.sv
// CPU16-side memory with programmable wait states, driven through the CPU hold input.
// Optional feature: define CPU_MEM_OOR_ERR_EN to add the sticky oor_err output, which
// flags any access outside the served window.
module cpu_wait_mem
  import cpu16_pkg::*;
#(
  parameter int unsigned DATA_W      = CPU16_DATA_W,
  parameter int unsigned ADDR_W      = CPU16_ADDR_W,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BASE_ADDR   = 'h8000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     dataOut,
  input  logic                  write,
  input  logic                  busy,
  output logic                  hold,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [DATA_W-1:0]     dataIn
`ifdef CPU_MEM_OOR_ERR_EN
  ,
  output logic                  oor_err
`endif
);

  if (WAIT_STATES > 15) begin : g_ws_check
    $error("cpu_wait_mem: WAIT_STATES must be in 0..15");
  end

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        WaitInit = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  mem_state_t              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]       last_addr_q, last_addr_d;
  logic                    last_write_q, last_write_d;
  logic                    acc_we_q, acc_we_d;
  logic                    acc_hit_q, acc_hit_d;
  logic                    rd_zero_q, rd_zero_d;
  logic                    addr_hit, new_acc;
  logic                    ram_we, ram_re;
  logic [DEPTH_LOG2-1:0]   ram_raddr;
  logic [DATA_W-1:0]       ram_rdata;

  assign addr_hit = (address[ADDR_W-1:DEPTH_LOG2] == BaseAddr[ADDR_W-1:DEPTH_LOG2]);

  // A new access is an address change or a rising write strobe, seen while the CPU is busy
  // and out of reset. DONE is the last cycle of an access, so it may start the next one;
  // that keeps the zero-wait build a true single-cycle memory.
  assign new_acc = reset && busy && (state_q != WAIT) &&
                   ((address != last_addr_q) || (write && !last_write_q));

  // Next-state, hold and read-port control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_addr_d  = last_addr_q;
    last_write_d = write;
    acc_we_d     = acc_we_q;
    acc_hit_d    = acc_hit_q;
    rd_zero_d    = rd_zero_q;
    hold         = 1'b0;
    ram_re       = 1'b0;
    ram_raddr    = last_addr_q[DEPTH_LOG2-1:0];

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (new_acc) begin
          last_addr_d = address;
          acc_we_d    = write;
          acc_hit_d   = addr_hit;
          if (WAIT_STATES == 0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitInit;
            hold    = 1'b1;
          end
        end
      end
      WAIT: begin
        // Hold drops one cycle before DONE so the CPU samples dataIn as it resumes.
        hold = (cnt_q != 4'd0);
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is captured on the edge entering DONE, so it is valid throughout DONE.
    if ((state_d == DONE) && !acc_we_d) begin
      rd_zero_d = !acc_hit_d;
      ram_re    = acc_hit_d;
      ram_raddr = last_addr_d[DEPTH_LOG2-1:0];
    end
  end

  // Access state registers; RAM contents survive reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_addr_q  <= '1;
      last_write_q <= 1'b0;
      acc_we_q     <= 1'b0;
      acc_hit_q    <= 1'b0;
      rd_zero_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_addr_q  <= last_addr_d;
      last_write_q <= last_write_d;
      acc_we_q     <= acc_we_d;
      acc_hit_q    <= acc_hit_d;
      rd_zero_q    <= rd_zero_d;
    end
  end

  // Writes commit at the end of DONE; misses are dropped.
  assign ram_we = (state_q == DONE) && acc_we_q && acc_hit_q;

  assign dataIn = rd_zero_q ? '0 : ram_rdata;

  cpu_mem_ram #(
    .DataW     (DATA_W),
    .DepthLog2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i     (clk),
    .we_i      (ram_we),
    .waddr_i   (last_addr_q[DEPTH_LOG2-1:0]),
    .wdata_i   (dataOut),
    .re_i      (ram_re),
    .raddr_i   (ram_raddr),
    .ld_en_i   (ld_en),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .rdata_o   (ram_rdata)
  );

`ifdef CPU_MEM_OOR_ERR_EN
  logic oor_err_q, oor_err_d;

  // Sticky out-of-range flag, cleared only by reset.
  always_comb begin
    oor_err_d = oor_err_q | (new_acc && !addr_hit);
  end

  // Out-of-range flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oor_err_q <= 1'b0;
    end else begin
      oor_err_q <= oor_err_d;
    end
  end

  assign oor_err = oor_err_q;
`endif

endmodule

// File: tb/tb_cpu_wait_mem.sv
// Directed bench for cpu_wait_mem: three instances (0, 1 and 3 wait states) share one
// stimulus bus; each check targets the instance whose timing it describes.
module tb_cpu_wait_mem;

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic [15:0] dataOut;
  logic        write;
  logic        busy;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [15:0] ld_data;
  logic        hold0, hold1, hold3;
  logic [15:0] din0, din1, din3;
`ifdef CPU_MEM_OOR_ERR_EN
  logic        oor0, oor1, oor3;
`endif

  int n_chk;
  int n_fail;

  cpu_wait_mem #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .address(address), .dataOut(dataOut), .write(write),
    .busy(busy), .hold(hold0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dataIn(din0)
`ifdef CPU_MEM_OOR_ERR_EN
    , .oor_err(oor0)
`endif
  );

  cpu_wait_mem #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .address(address), .dataOut(dataOut), .write(write),
    .busy(busy), .hold(hold1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dataIn(din1)
`ifdef CPU_MEM_OOR_ERR_EN
    , .oor_err(oor1)
`endif
  );

  cpu_wait_mem #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .address(address), .dataOut(dataOut), .write(write),
    .busy(busy), .hold(hold3), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dataIn(din3)
`ifdef CPU_MEM_OOR_ERR_EN
    , .oor_err(oor3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        exp_hold;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [9:0]  idx;
    logic [15:0] data;
  } pl_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    vec_t  ws0_vec [4];
    pl_t   pl [7];
    logic  ws1_hold [6];
    logic  ws3_hold [6];
    logic [15:0] ws1_din [6];
    logic [15:0] ws3_din [6];
    int    hold_cnt;

    pl[0] = '{10'h000, 16'hd950};
    pl[1] = '{10'h001, 16'h1111};
    pl[2] = '{10'h002, 16'h2222};
    pl[3] = '{10'h003, 16'h3333};
    pl[4] = '{10'h004, 16'h4444};
    pl[5] = '{10'h005, 16'h0000};
    pl[6] = '{10'h050, 16'h5050};

    // Zero-wait instance: dataIn shows the previous cycle's address data.
    ws0_vec[0] = '{16'h8001, 1'b0, 16'hd950};
    ws0_vec[1] = '{16'h8002, 1'b0, 16'h1111};
    ws0_vec[2] = '{16'h8003, 1'b0, 16'h2222};
    ws0_vec[3] = '{16'h8000, 1'b0, 16'h3333};

    ws1_hold = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ws3_hold = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ws1_din  = '{16'h0, 16'h0, 16'hd950, 16'hd950, 16'hd950, 16'hd950};
    ws3_din  = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hd950, 16'hd950};

    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    busy    = 1'b0;
    write   = 1'b0;
    address = 16'hffff;
    dataOut = 16'h0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    // Reset state.
    settle(2);
    @(negedge clk);
    chk("rst_hold0", 32'(hold0), 32'h0);
    chk("rst_hold1", 32'(hold1), 32'h0);
    chk("rst_hold3", 32'(hold3), 32'h0);
    chk("rst_din0", 32'(din0), 32'h0);
    chk("rst_din1", 32'(din1), 32'h0);
    chk("rst_din3", 32'(din3), 32'h0);
`ifdef CPU_MEM_OOR_ERR_EN
    chk("rst_oor1", 32'(oor1), 32'h0);
`endif

    // Preload while reset is held.
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      ld_en   = 1'b1;
      ld_addr = pl[i].idx;
      ld_data = pl[i].data;
      next_cycle();
    end
    ld_en = 1'b0;
    reset = 1'b1;
    busy  = 1'b1;
    next_cycle();

    // Single read of 0x8000 seen by all three wait-state settings.
    address = 16'h8000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("a_hold0_c%0d", c), 32'(hold0), 32'h0);
      chk($sformatf("a_hold1_c%0d", c), 32'(hold1), 32'(ws1_hold[c]));
      chk($sformatf("a_hold3_c%0d", c), 32'(hold3), 32'(ws3_hold[c]));
      chk($sformatf("a_din1_c%0d", c), 32'(din1), 32'(ws1_din[c]));
      chk($sformatf("a_din3_c%0d", c), 32'(din3), 32'(ws3_din[c]));
      if (c > 0) chk($sformatf("a_din0_c%0d", c), 32'(din0), 32'hd950);
      next_cycle();
    end

    // Back-to-back reads on the zero-wait instance.
    for (int k = 0; k < 4; k++) begin
      address = ws0_vec[k].addr;
      @(negedge clk);
      chk($sformatf("b_hold0_%0d", k), 32'(hold0), 32'(ws0_vec[k].exp_hold));
      chk($sformatf("b_din0_%0d", k), 32'(din0), 32'(ws0_vec[k].exp_data));
      next_cycle();
    end
    @(negedge clk);
    chk("b_din0_last", 32'(din0), 32'hd950);
    settle(12);
    @(negedge clk);
    chk("b_din1_settled", 32'(din1), 32'hd950);
    chk("b_din3_settled", 32'(din3), 32'hd950);
    next_cycle();

    // Write 0x4829 to 0x8005 with three wait states.
    address  = 16'h8005;
    dataOut  = 16'h4829;
    write    = 1'b1;
    hold_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("c_wr_hold3_c%0d", c), 32'(hold3), 32'(ws3_hold[c]));
      if (hold3) hold_cnt++;
      next_cycle();
    end
    chk("c_wr_hold3_count", 32'(hold_cnt), 32'd3);
    write   = 1'b0;
    address = 16'h8004;
    settle(6);
    @(negedge clk);
    chk("c_din3_8004", 32'(din3), 32'h4444);
    next_cycle();

    // Read back 0x8005.
    address  = 16'h8005;
    hold_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("c_rd_hold3_c%0d", c), 32'(hold3), 32'(ws3_hold[c]));
      if (hold3) hold_cnt++;
      if (c == 4) chk("c_rd_din3", 32'(din3), 32'h4829);
      next_cycle();
    end
    chk("c_rd_hold3_count", 32'(hold_cnt), 32'd3);
    @(negedge clk);
    chk("c_rd_din0", 32'(din0), 32'h4829);
    chk("c_rd_din1", 32'(din1), 32'h4829);
    next_cycle();

    // Miss at 0x0050: read returns 0, write is dropped.
    address = 16'h0050;
    settle(6);
    @(negedge clk);
    chk("d_miss_din0", 32'(din0), 32'h0);
    chk("d_miss_din1", 32'(din1), 32'h0);
    chk("d_miss_din3", 32'(din3), 32'h0);
`ifdef CPU_MEM_OOR_ERR_EN
    chk("d_oor0", 32'(oor0), 32'h1);
    chk("d_oor1", 32'(oor1), 32'h1);
    chk("d_oor3", 32'(oor3), 32'h1);
`endif
    next_cycle();
    dataOut = 16'hbeef;
    write   = 1'b1;
    settle(6);
    write   = 1'b0;
    address = 16'h8050;
    settle(6);
    @(negedge clk);
    chk("d_word50_din0", 32'(din0), 32'h5050);
    chk("d_word50_din1", 32'(din1), 32'h5050);
    chk("d_word50_din3", 32'(din3), 32'h5050);
`ifdef CPU_MEM_OOR_ERR_EN
    chk("d_oor1_sticky", 32'(oor1), 32'h1);
`endif
    next_cycle();

    // Reset during the wait phase of a write to 0x8003.
    address = 16'h8003;
    dataOut = 16'hdead;
    write   = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("e_hold3_before", 32'(hold3), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("e_hold3_rst", 32'(hold3), 32'h0);
    chk("e_hold1_rst", 32'(hold1), 32'h0);
    chk("e_hold0_rst", 32'(hold0), 32'h0);
    write   = 1'b0;
    address = 16'hffff;
    settle(2);
    @(negedge clk);
    chk("e_din3_rst", 32'(din3), 32'h0);
`ifdef CPU_MEM_OOR_ERR_EN
    chk("e_oor1_rst", 32'(oor1), 32'h0);
`endif
    next_cycle();
    reset = 1'b1;
    next_cycle();
    address = 16'h8003;
    settle(6);
    @(negedge clk);
    chk("e_word3_din0", 32'(din0), 32'h3333);
    chk("e_word3_din1", 32'(din1), 32'h3333);
    chk("e_word3_din3", 32'(din3), 32'h3333);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
